// File: rtl/register_file_clr.sv
// register_file_clr: multi-ported register file with a sequential clear engine.
// The file has one write port and two independent combinational read ports.
// Optional features:
//   - register 0 can be hardwired to zero (ZERO_REG)
//   - a write can be forwarded to the read ports in the same cycle (BYPASS)
// The clear engine wipes one register per clock, from address 0 up to
// DEPTH-1. While it runs, writes are blocked and forwarding is disabled.
// i_reset_n is an asynchronous, active-low reset.
module register_file_clr #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned ADDR_W   = 2,
  parameter bit          ZERO_REG = 1'b0,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr_input,
  input  logic [WIDTH-1:0]  i_data,
  input  logic [ADDR_W-1:0] i_addr_out1,
  input  logic [ADDR_W-1:0] i_addr_out2,
  input  logic              i_clr_start,
  output logic [WIDTH-1:0]  o_out1,
  output logic [WIDTH-1:0]  o_out2,
  output logic              o_busy,
  output logic              o_clr_done
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  // Clear engine states.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_clr_done;
  logic [WIDTH-1:0]  r_mem [DEPTH];

  logic w_busy;
  logic w_write_en;
  logic w_last;

  // The engine is busy for as long as it is in the CLEAR state.
  assign w_busy = (r_state == ST_CLEAR);

  // A write takes effect only when the engine is idle and the write does not
  // target the hardwired zero register.
  assign w_write_en = i_we && !w_busy && !(ZERO_REG && (i_addr_input == '0));

  // The counter is on the last register when all of its bits are set.
  assign w_last = (r_cnt == '1);

  assign o_busy     = w_busy;
  assign o_clr_done = r_clr_done;

  // Clear engine: sequence the counter across every address, then raise a
  // one-cycle done pulse on the edge where busy drops.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_clr_done <= 1'b0;
    end else begin
      r_clr_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_clr_start) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
          end
        end
        ST_CLEAR: begin
          if (w_last) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_clr_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt + ADDR_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Storage update. While clearing, zero the register the counter points at
  // and ignore writes. Otherwise perform the requested write. A write sampled
  // on the same edge that starts a clear still lands, because the engine is
  // still idle on that edge.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_busy) begin
      r_mem[r_cnt] <= '0;
    end else if (w_write_en) begin
      r_mem[i_addr_input] <= i_data;
    end
  end

  // Read port 1. Forwarding is applied before the zero-register override, so
  // address 0 always reads as zero when it is hardwired.
  always_comb begin
    o_out1 = r_mem[i_addr_out1];
    if (BYPASS && w_write_en && (i_addr_out1 == i_addr_input)) begin
      o_out1 = i_data;
    end
    if (ZERO_REG && (i_addr_out1 == '0)) begin
      o_out1 = '0;
    end
  end

  // Read port 2 follows the same rules as port 1, independently.
  always_comb begin
    o_out2 = r_mem[i_addr_out2];
    if (BYPASS && w_write_en && (i_addr_out2 == i_addr_input)) begin
      o_out2 = i_data;
    end
    if (ZERO_REG && (i_addr_out2 == '0)) begin
      o_out2 = '0;
    end
  end

endmodule

// File: tb/tb_register_file_clr.sv
// tb_register_file_clr: three instances of register_file_clr share one stimulus.
//   dut0 : default configuration (8-bit data, 4 registers, forwarding on)
//   dut1 : hardwired zero register, no forwarding
//   dut2 : 16-bit data, 8 registers
// A behavioural model tracks all three instances on every clock edge.
module tb_register_file_clr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [2:0]  waddr;
  logic [15:0] wdata;
  logic [2:0]  ra1;
  logic [2:0]  ra2;
  logic        clrStart;

  logic [7:0]  o1_0, o2_0, o1_1, o2_1;
  logic [15:0] o1_2, o2_2;
  logic        busy0, busy1, busy2, done0, done1, done2;

  int checks = 0;
  int errors = 0;

  // Model state.
  int          mDepth  [3] = '{4, 4, 8};
  bit          mZero   [3] = '{1'b0, 1'b1, 1'b0};
  bit          mBypass [3] = '{1'b1, 1'b0, 1'b1};
  logic [15:0] mMask   [3] = '{16'h00FF, 16'h00FF, 16'hFFFF};
  logic [15:0] mMem    [3][8];
  int          mPos    [3];
  bit          mDone   [3];

  always #5 clk = ~clk;

  register_file_clr dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_we(we), .i_addr_input(waddr[1:0]),
    .i_data(wdata[7:0]), .i_addr_out1(ra1[1:0]), .i_addr_out2(ra2[1:0]),
    .i_clr_start(clrStart), .o_out1(o1_0), .o_out2(o2_0),
    .o_busy(busy0), .o_clr_done(done0)
  );

  register_file_clr #(.ZERO_REG(1'b1), .BYPASS(1'b0)) dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_we(we), .i_addr_input(waddr[1:0]),
    .i_data(wdata[7:0]), .i_addr_out1(ra1[1:0]), .i_addr_out2(ra2[1:0]),
    .i_clr_start(clrStart), .o_out1(o1_1), .o_out2(o2_1),
    .o_busy(busy1), .o_clr_done(done1)
  );

  register_file_clr #(.WIDTH(16), .ADDR_W(3)) dut2 (
    .i_clk(clk), .i_reset_n(rst_n), .i_we(we), .i_addr_input(waddr),
    .i_data(wdata), .i_addr_out1(ra1), .i_addr_out2(ra2),
    .i_clr_start(clrStart), .o_out1(o1_2), .o_out2(o2_2),
    .o_busy(busy2), .o_clr_done(done2)
  );

  // Return every modelled instance to its reset state.
  task automatic modelReset();
    for (int k = 0; k < 3; k++) begin
      for (int a = 0; a < 8; a++) mMem[k][a] = 16'h0;
      mPos[k]  = -1;
      mDone[k] = 1'b0;
    end
  endtask

  // Apply one rising edge to the model, using the inputs held at that edge.
  task automatic modelEdge();
    int a;
    if (!rst_n) begin
      modelReset();
      return;
    end
    for (int k = 0; k < 3; k++) begin
      a = int'(waddr) % mDepth[k];
      mDone[k] = 1'b0;
      if (mPos[k] < 0) begin
        if (we && !(mZero[k] && a == 0)) mMem[k][a] = wdata & mMask[k];
        if (clrStart) mPos[k] = 0;
      end else begin
        mMem[k][mPos[k]] = 16'h0;
        if (mPos[k] == mDepth[k] - 1) begin
          mPos[k]  = -1;
          mDone[k] = 1'b1;
        end else begin
          mPos[k] = mPos[k] + 1;
        end
      end
    end
  endtask

  // Value the model expects on a read port for the given read address.
  function automatic logic [15:0] expRead(int k, logic [2:0] ra);
    int a  = int'(ra) % mDepth[k];
    int wa = int'(waddr) % mDepth[k];
    if (mZero[k] && a == 0) return 16'h0;
    if (mBypass[k] && we && mPos[k] < 0 && wa == a) return wdata & mMask[k];
    return mMem[k][a];
  endfunction

  // One clock: model and DUTs see the rising edge; return at the falling edge.
  task automatic stepClock();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
  endtask

  // Let any clear in progress finish, with a bounded number of cycles.
  task automatic waitIdle();
    for (int n = 0; n < 20 && (busy0 || busy1 || busy2); n++) stepClock();
    stepClock();
    checks++;
    if (busy0 || busy1 || busy2) begin
      errors++;
      $display("[TB] FAIL wait_idle got busy %b%b%b exp 000", busy0, busy1, busy2);
    end
  endtask

  task automatic test_reset();
    for (int a = 0; a < 4; a++) begin
      ra1 = 3'(a); ra2 = 3'(a); #1;
      checks++; if (o1_0 !== 8'h00) begin errors++; $display("[TB] FAIL reset_out1 a=%0d got %h exp 00", a, o1_0); end
      checks++; if (o2_2 !== 16'h0) begin errors++; $display("[TB] FAIL reset_out2_w16 a=%0d got %h exp 0000", a, o2_2); end
    end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b exp 0", busy0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b exp 0", done0); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write();
    we = 1'b1; waddr = 3'd1; wdata = 16'h00A5; stepClock();
    waddr = 3'd2; wdata = 16'h003C; stepClock();
    we = 1'b0; ra1 = 3'd1; ra2 = 3'd2; #1;
    checks++; if (o1_0 !== 8'hA5) begin errors++; $display("[TB] FAIL write_out1 got %h exp a5", o1_0); end
    checks++; if (o2_0 !== 8'h3C) begin errors++; $display("[TB] FAIL write_out2 got %h exp 3c", o2_0); end
    checks++; if (o1_1 !== 8'hA5) begin errors++; $display("[TB] FAIL write_out1_zr got %h exp a5", o1_1); end
    checks++; if (o2_2 !== 16'h003C) begin errors++; $display("[TB] FAIL write_out2_w16 got %h exp 003c", o2_2); end
  endtask

  task automatic test_bypass();
    we = 1'b1; waddr = 3'd3; wdata = 16'h0077; ra1 = 3'd3; #1;
    checks++; if (o1_0 !== 8'h77) begin errors++; $display("[TB] FAIL bypass_on got %h exp 77", o1_0); end
    checks++; if (o1_1 !== 8'h00) begin errors++; $display("[TB] FAIL bypass_off_before got %h exp 00", o1_1); end
    checks++; if (o1_2 !== 16'h0077) begin errors++; $display("[TB] FAIL bypass_on_w16 got %h exp 0077", o1_2); end
    stepClock();
    we = 1'b0; #1;
    checks++; if (o1_1 !== 8'h77) begin errors++; $display("[TB] FAIL bypass_off_after got %h exp 77", o1_1); end
    checks++; if (o1_0 !== 8'h77) begin errors++; $display("[TB] FAIL bypass_on_after got %h exp 77", o1_0); end
  endtask

  task automatic test_zero_reg();
    we = 1'b1; waddr = 3'd0; wdata = 16'h00FF; ra1 = 3'd0; #1;
    checks++; if (o1_1 !== 8'h00) begin errors++; $display("[TB] FAIL zero_same_cycle got %h exp 00", o1_1); end
    checks++; if (o1_0 !== 8'hFF) begin errors++; $display("[TB] FAIL zero_normal_bypass got %h exp ff", o1_0); end
    stepClock();
    waddr = 3'd1; ra2 = 3'd1; #1;
    checks++; if (o1_1 !== 8'h00) begin errors++; $display("[TB] FAIL zero_after_write got %h exp 00", o1_1); end
    checks++; if (o1_0 !== 8'hFF) begin errors++; $display("[TB] FAIL zero_normal_r0 got %h exp ff", o1_0); end
    checks++; if (o2_1 !== 8'hA5) begin errors++; $display("[TB] FAIL zero_r1_old got %h exp a5", o2_1); end
    stepClock();
    we = 1'b0; #1;
    checks++; if (o2_1 !== 8'hFF) begin errors++; $display("[TB] FAIL zero_r1_new got %h exp ff", o2_1); end
  endtask

  task automatic test_clear();
    logic [7:0] fill;
    for (int a = 0; a < 4; a++) begin
      we = 1'b1; waddr = 3'(a); wdata = 16'(8'h11 * (a + 1)); stepClock();
    end
    we = 1'b0; clrStart = 1'b1; ra1 = 3'd0; ra2 = 3'd3; #1;
    checks++; if (busy0 !== 1'b0) begin errors++; $display("[TB] FAIL clear_busy_pre got %b exp 0", busy0); end
    stepClock();
    clrStart = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fill = 8'(8'h11 * (i + 1));
      we = 1'b1; waddr = 3'd3; wdata = 16'h0099; ra1 = 3'(i); ra2 = 3'd3; #1;
      checks++; if (busy0 !== 1'b1) begin errors++; $display("[TB] FAIL clear_busy i=%0d got %b exp 1", i, busy0); end
      checks++; if (done0 !== 1'b0) begin errors++; $display("[TB] FAIL clear_done_early i=%0d got %b exp 0", i, done0); end
      checks++; if (o1_0 !== fill) begin errors++; $display("[TB] FAIL clear_pending i=%0d got %h exp %h", i, o1_0, fill); end
      checks++; if (o2_0 !== 8'h44) begin errors++; $display("[TB] FAIL clear_r3_kept i=%0d got %h exp 44", i, o2_0); end
      if (i > 0) begin
        ra2 = 3'(i - 1); #1;
        checks++; if (o2_0 !== 8'h00) begin errors++; $display("[TB] FAIL clear_done_addr i=%0d got %h exp 00", i, o2_0); end
      end
      stepClock();
    end
    we = 1'b0; ra1 = 3'd3; #1;
    checks++; if (busy0 !== 1'b0) begin errors++; $display("[TB] FAIL clear_busy_end got %b exp 0", busy0); end
    checks++; if (done0 !== 1'b1) begin errors++; $display("[TB] FAIL clear_done_pulse got %b exp 1", done0); end
    checks++; if (o1_0 !== 8'h00) begin errors++; $display("[TB] FAIL clear_r3_zero got %h exp 00", o1_0); end
    stepClock(); #1;
    checks++; if (done0 !== 1'b0) begin errors++; $display("[TB] FAIL clear_done_width got %b exp 0", done0); end
  endtask

  task automatic test_reset_mid_clear();
    waitIdle();
    clrStart = 1'b1; stepClock();
    clrStart = 1'b0; stepClock(); stepClock();
    rst_n = 1'b0;
    for (int a = 0; a < 4; a++) begin
      ra1 = 3'(a); ra2 = 3'(a); #1;
      checks++; if (o1_0 !== 8'h00) begin errors++; $display("[TB] FAIL abort_out1 a=%0d got %h exp 00", a, o1_0); end
      checks++; if (o2_2 !== 16'h0) begin errors++; $display("[TB] FAIL abort_out2_w16 a=%0d got %h exp 0000", a, o2_2); end
    end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got %b exp 0", busy0); end
    for (int n = 0; n < 3; n++) begin
      stepClock(); #1;
      checks++; if (done0 !== 1'b0) begin errors++; $display("[TB] FAIL abort_done n=%0d got %b exp 0", n, done0); end
    end
    rst_n = 1'b1; we = 1'b1; waddr = 3'd2; wdata = 16'h005A; stepClock();
    we = 1'b0; ra2 = 3'd2; #1;
    checks++; if (o2_0 !== 8'h5A) begin errors++; $display("[TB] FAIL abort_write got %h exp 5a", o2_0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("[TB] FAIL abort_done_after got %b exp 0", done0); end
  endtask

  task automatic test_addr8();
    waitIdle();
    we = 1'b1; waddr = 3'd7; wdata = 16'hBEEF; stepClock();
    we = 1'b0; ra1 = 3'd7; clrStart = 1'b1; #1;
    checks++; if (o1_2 !== 16'hBEEF) begin errors++; $display("[TB] FAIL w16_written got %h exp beef", o1_2); end
    stepClock();
    for (int i = 0; i < 8; i++) begin
      clrStart = (i == 3); #1;
      checks++; if (busy2 !== 1'b1) begin errors++; $display("[TB] FAIL w16_busy i=%0d got %b exp 1", i, busy2); end
      checks++; if (o1_2 !== 16'hBEEF) begin errors++; $display("[TB] FAIL w16_r7_kept i=%0d got %h exp beef", i, o1_2); end
      stepClock();
    end
    clrStart = 1'b1; #1;
    checks++; if (busy2 !== 1'b0) begin errors++; $display("[TB] FAIL w16_busy_end got %b exp 0", busy2); end
    checks++; if (done2 !== 1'b1) begin errors++; $display("[TB] FAIL w16_done got %b exp 1", done2); end
    checks++; if (o1_2 !== 16'h0) begin errors++; $display("[TB] FAIL w16_r7_zero got %h exp 0000", o1_2); end
    stepClock();
    clrStart = 1'b0; #1;
    checks++; if (busy2 !== 1'b1) begin errors++; $display("[TB] FAIL w16_restart got %b exp 1", busy2); end
    checks++; if (done2 !== 1'b0) begin errors++; $display("[TB] FAIL w16_done_width got %b exp 0", done2); end
  endtask

  task automatic test_random();
    logic [15:0] got1, got2, exp1, exp2;
    logic        gotBusy, gotDone;
    waitIdle();
    for (int c = 0; c < 300; c++) begin
      we = 1'($urandom_range(0, 1));
      waddr = 3'($urandom); wdata = 16'($urandom);
      ra1 = 3'($urandom); ra2 = 3'($urandom);
      clrStart = ($urandom_range(0, 11) == 0);
      #1;
      for (int k = 0; k < 3; k++) begin
        got1 = (k == 0) ? {8'h0, o1_0} : (k == 1) ? {8'h0, o1_1} : o1_2;
        got2 = (k == 0) ? {8'h0, o2_0} : (k == 1) ? {8'h0, o2_1} : o2_2;
        gotBusy = (k == 0) ? busy0 : (k == 1) ? busy1 : busy2;
        gotDone = (k == 0) ? done0 : (k == 1) ? done1 : done2;
        exp1 = expRead(k, ra1);
        exp2 = expRead(k, ra2);
        checks++; if (got1 !== exp1) begin errors++; $display("[TB] FAIL rand_out1 dut%0d c=%0d got %h exp %h", k, c, got1, exp1); end
        checks++; if (got2 !== exp2) begin errors++; $display("[TB] FAIL rand_out2 dut%0d c=%0d got %h exp %h", k, c, got2, exp2); end
        checks++; if (gotBusy !== (mPos[k] >= 0)) begin errors++; $display("[TB] FAIL rand_busy dut%0d c=%0d got %b exp %b", k, c, gotBusy, mPos[k] >= 0); end
        checks++; if (gotDone !== mDone[k]) begin errors++; $display("[TB] FAIL rand_done dut%0d c=%0d got %b exp %b", k, c, gotDone, mDone[k]); end
      end
      stepClock();
    end
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; waddr = 3'd0; wdata = 16'h0;
    ra1 = 3'd0; ra2 = 3'd0; clrStart = 1'b0;
    modelReset();
    test_reset();
    test_write();
    test_bypass();
    test_zero_reg();
    test_clear();
    test_reset_mid_clear();
    test_addr8();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
